// File: rtl/macc_pkg.sv
// Shared types and constants for the matrix multiply-accumulate engine.
package macc_pkg;

    // Sequencer states: one element costs LOAD + N*RUN + DRAIN_CYCLES*DRAIN + WRITE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Cycles needed to flush the RAM-read and product-register stages.
    localparam int DRAIN_CYCLES = 2;

    // Bit positions of the banks inside wen/ren.
    localparam int BANK_A = 2;
    localparam int BANK_B = 1;
    localparam int BANK_C = 0;

endpackage

// File: rtl/macc_if.sv
// Host-side word port and control/status bundle of the MACC engine.
interface macc_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
);
    logic [2:0]          wen;
    logic [2:0]          ren;
    logic [2*IDX_W-1:0]  addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic [IDX_W:0]      dim;
    logic                acc_mode;
    logic                start;
    logic                busy;
    logic                done;
    logic                err;
    logic                ovf;

    modport master (
        output wen, ren, addr, wdata, dim, acc_mode, start,
        input  rdata, busy, done, err, ovf
    );

    modport slave (
        input  wen, ren, addr, wdata, dim, acc_mode, start,
        output rdata, busy, done, err, ovf
    );
endinterface

// File: rtl/macc_bank.sv
// Single-port matrix RAM with a registered read; contents are not reset.
module macc_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Write port plus one-cycle registered read of the same address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end
endmodule

// File: rtl/macc_engine.sv
// Matrix store (A, B, C) with an on-chip sequencer computing C = A*B or C += A*B.
module macc_engine
    import macc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6,
    parameter int ACC_W  = 2*DATA_W + IDX_W
) (
    input logic   CLK,
    input logic   RST,
    macc_if.slave bus
);
    localparam int ADDR_W = 2*IDX_W;
    localparam logic [IDX_W:0] MAX_N = {1'b1, {IDX_W{1'b0}}};

    state_e              state_r, state_s;
    logic [IDX_W:0]      n_r, n_m1_s;
    logic                mode_r, ovf_r, err_r;
    logic [IDX_W-1:0]    i_r, j_r, k_r;
    logic [1:0]          drain_r;
    logic                v1_r, v2_r;
    logic [2*DATA_W-1:0] prod_r;
    logic [ACC_W-1:0]    acc_r, sum_s;
    logic [2:0]          sel_r;
    logic                busy_s, done_s, start_ok_s, start_bad_s;
    logic                k_last_s, j_last_s, i_last_s, drain_last_s;
    logic [DATA_W-1:0]   qa_s, qb_s, qc_s, rdata_s;

    // True when v is representable as a signed DATA_W value.
    function automatic logic fits_data(input logic [ACC_W-1:0] v);
        logic [ACC_W-DATA_W:0] top;
        top = v[ACC_W-1:DATA_W-1];
        return (&top) | ~(|top);
    endfunction

    assign n_m1_s       = n_r - {{IDX_W{1'b0}}, 1'b1};
    assign k_last_s     = ({1'b0, k_r} == n_m1_s);
    assign j_last_s     = ({1'b0, j_r} == n_m1_s);
    assign i_last_s     = ({1'b0, i_r} == n_m1_s);
    assign drain_last_s = (drain_r == 2'(DRAIN_CYCLES - 1));
    assign start_ok_s   = (state_r == IDLE) && bus.start &&
                          (bus.dim != {(IDX_W+1){1'b0}}) && (bus.dim <= MAX_N);
    assign start_bad_s  = (state_r == IDLE) && bus.start && !start_ok_s;

    // Final element value: dot product plus the old C element in accumulate mode.
    assign sum_s = acc_r + (mode_r ? {{(ACC_W-DATA_W){qc_s[DATA_W-1]}}, qc_s}
                                   : {ACC_W{1'b0}});

    // Bank instances; the sequencer owns address and write controls while busy.
    macc_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank_a (
        .clk   (CLK),
        .we    (bus.wen[BANK_A] && !busy_s),
        .addr  (busy_s ? {i_r, k_r} : bus.addr),
        .wdata (bus.wdata),
        .rdata (qa_s)
    );

    macc_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank_b (
        .clk   (CLK),
        .we    (bus.wen[BANK_B] && !busy_s),
        .addr  (busy_s ? {k_r, j_r} : bus.addr),
        .wdata (bus.wdata),
        .rdata (qb_s)
    );

    macc_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank_c (
        .clk   (CLK),
        .we    (busy_s ? (state_r == WRITE) : bus.wen[BANK_C]),
        .addr  (busy_s ? {i_r, j_r} : bus.addr),
        .wdata (busy_s ? sum_s[DATA_W-1:0] : bus.wdata),
        .rdata (qc_s)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_s = LOAD;
                end else if (start_bad_s) begin
                    state_s = DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD:    state_s = RUN;
            RUN: begin
                if (k_last_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (drain_last_s) begin
                    state_s = WRITE;
                end else begin
                    state_s = DRAIN;
                end
            end
            WRITE: begin
                if (i_last_s && j_last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = LOAD;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            IDLE:    busy_s = 1'b0;
            DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: busy_s = 1'b1;
        endcase
    end

    // Sequencer counters, latched job parameters and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            n_r     <= {(IDX_W+1){1'b0}};
            mode_r  <= 1'b0;
            i_r     <= {IDX_W{1'b0}};
            j_r     <= {IDX_W{1'b0}};
            k_r     <= {IDX_W{1'b0}};
            drain_r <= 2'd0;
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            err_r <= start_bad_s;
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        n_r    <= bus.dim;
                        mode_r <= bus.acc_mode;
                        ovf_r  <= 1'b0;
                        i_r    <= {IDX_W{1'b0}};
                        j_r    <= {IDX_W{1'b0}};
                    end
                end
                LOAD: begin
                    k_r     <= {IDX_W{1'b0}};
                    drain_r <= 2'd0;
                end
                RUN:   k_r <= k_r + {{(IDX_W-1){1'b0}}, 1'b1};
                DRAIN: drain_r <= drain_r + 2'd1;
                WRITE: begin
                    if (!fits_data(sum_s)) begin
                        ovf_r <= 1'b1;
                    end
                    if (j_last_s) begin
                        j_r <= {IDX_W{1'b0}};
                        i_r <= i_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end else begin
                        j_r <= j_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    // Multiply-accumulate pipeline: RAM data -> product register -> accumulator.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_r   <= 1'b0;
            v2_r   <= 1'b0;
            prod_r <= {(2*DATA_W){1'b0}};
            acc_r  <= {ACC_W{1'b0}};
        end else begin
            v1_r   <= (state_r == RUN);
            v2_r   <= v1_r;
            prod_r <= {{DATA_W{qa_s[DATA_W-1]}}, qa_s} * {{DATA_W{qb_s[DATA_W-1]}}, qb_s};
            if (state_r == LOAD) begin
                acc_r <= {ACC_W{1'b0}};
            end else if (v2_r) begin
                acc_r <= acc_r + {{(ACC_W-2*DATA_W){prod_r[2*DATA_W-1]}}, prod_r};
            end
        end
    end

    // Host read-bank select, registered alongside the RAM read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_r <= 3'b000;
        end else begin
            sel_r <= busy_s ? 3'b000 : bus.ren;
        end
    end

    // Host read mux with A > B > C priority; forced to zero while busy.
    always_comb begin
        rdata_s = {DATA_W{1'b0}};
        if (busy_s) begin
            rdata_s = {DATA_W{1'b0}};
        end else if (sel_r[BANK_A]) begin
            rdata_s = qa_s;
        end else if (sel_r[BANK_B]) begin
            rdata_s = qb_s;
        end else if (sel_r[BANK_C]) begin
            rdata_s = qc_s;
        end else begin
            rdata_s = {DATA_W{1'b0}};
        end
    end

    assign bus.rdata = rdata_s;
    assign bus.busy  = busy_s;
    assign bus.done  = done_s;
    assign bus.err   = err_r;
    assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_macc_engine.sv
// Scoreboard bench for macc_engine at a reduced MAX_N so full-size runs stay short.
module tb_macc_engine;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 3;
    localparam int MAX_N  = 1 << IDX_W;
    localparam int DEPTH  = MAX_N * MAX_N;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    macc_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    macc_engine #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] ma [DEPTH];
    logic [DATA_W-1:0] mb [DEPTH];
    logic [DATA_W-1:0] mc [DEPTH];
    logic              exp_ovf;

    logic [DATA_W-1:0] exp_q [$];
    string             tag_q [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic host_write(input int bank, input int r, input int c, input logic [DATA_W-1:0] v);
        bus.wen   = 3'b001 << bank;
        bus.addr  = {r[IDX_W-1:0], c[IDX_W-1:0]};
        bus.wdata = v;
        tick();
        bus.wen = 3'b000;
        case (bank)
            2:       ma[r*MAX_N + c] = v;
            1:       mb[r*MAX_N + c] = v;
            default: mc[r*MAX_N + c] = v;
        endcase
    endtask

    // Issue a read, queue its expectation, compare once rdata is due.
    task automatic host_read(input int bank, input int r, input int c,
                             input logic [DATA_W-1:0] e, input string tag);
        bus.ren  = 3'b001 << bank;
        bus.addr = {r[IDX_W-1:0], c[IDX_W-1:0]};
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick();
        bus.ren = 3'b000;
        check_val(tag_q.pop_front(), 64'(bus.rdata), 64'(exp_q.pop_front()));
    endtask

    // Reference model of one job over the N x N top-left corner.
    task automatic model_mul(input int n, input bit mode);
        logic signed [127:0] s;
        exp_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                if (mode) s = $signed(mc[i*MAX_N + j]);
                else      s = 128'sd0;
                for (int k = 0; k < n; k++) begin
                    s = s + ($signed(ma[i*MAX_N + k]) * $signed(mb[k*MAX_N + j]));
                end
                if (s > 128'sd2147483647 || s < -128'sd2147483648) exp_ovf = 1'b1;
                mc[i*MAX_N + j] = s[DATA_W-1:0];
            end
        end
    endtask

    task automatic pulse_start(input int n, input bit mode);
        bus.dim      = 4'(n);
        bus.acc_mode = mode;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Count busy cycles, done and err pulses until busy falls (bounded).
    task automatic wait_done(output int cyc, output int dn, output int er);
        cyc = 0; dn = 0; er = 0;
        while (bus.busy === 1'b1 && cyc < 5000) begin
            cyc++;
            if (bus.done === 1'b1) dn++;
            if (bus.err === 1'b1) er++;
            tick();
        end
        if (cyc >= 5000) check_val("timeout", 64'(cyc), 64'd0);
    endtask

    task automatic check_c(input int n, input string tag);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                host_read(0, r, c, mc[r*MAX_N + c], $sformatf("%s_c%0d%0d", tag, r, c));
            end
        end
    endtask

    task automatic load_ab2();
        host_write(2, 0, 0, 32'd1); host_write(2, 0, 1, 32'd2);
        host_write(2, 1, 0, 32'd3); host_write(2, 1, 1, 32'd4);
        host_write(1, 0, 0, 32'd5); host_write(1, 0, 1, 32'd6);
        host_write(1, 1, 0, 32'd7); host_write(1, 1, 1, 32'd8);
    endtask

    initial begin
        int cyc, dn, er, bsy;
        bus.wen = 3'b000; bus.ren = 3'b000; bus.addr = '0; bus.wdata = '0;
        bus.dim = '0; bus.acc_mode = 1'b0; bus.start = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            ma[a] = '0; mb[a] = '0; mc[a] = '0;
        end

        // Reset state.
        RST = 1'b1;
        tick(); tick(); tick();
        RST = 1'b0;
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_err", 64'(bus.err), 64'd0);
        check_val("rst_ovf", 64'(bus.ovf), 64'd0);
        check_val("rst_rdata", 64'(bus.rdata), 64'd0);

        // Plain 2x2 product.
        load_ab2();
        host_read(2, 1, 0, 32'd3, "rd_a10");
        host_read(1, 1, 1, 32'd8, "rd_b11");
        model_mul(2, 1'b0);
        check_val("mdl_c00", 64'(mc[0]), 64'd19);
        pulse_start(2, 1'b0);
        wait_done(cyc, dn, er);
        check_val("n2_busy", 64'(cyc), 64'd25);
        check_val("n2_done", 64'(dn), 64'd1);
        check_val("n2_err", 64'(er), 64'd0);
        check_val("n2_ovf", 64'(bus.ovf), 64'(exp_ovf));
        check_c(2, "n2");

        // Accumulate mode on a C preloaded with ones.
        for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) host_write(0, r, c, 32'd1);
        model_mul(2, 1'b1);
        check_val("mdl_acc11", 64'(mc[MAX_N + 1]), 64'd51);
        pulse_start(2, 1'b1);
        wait_done(cyc, dn, er);
        check_val("acc_busy", 64'(cyc), 64'd25);
        check_val("acc_done", 64'(dn), 64'd1);
        check_c(2, "acc");

        // Overflow with N=1, then a clean job clears the flag.
        host_write(2, 0, 0, 32'h7FFF_FFFF);
        host_write(1, 0, 0, 32'd2);
        model_mul(1, 1'b0);
        pulse_start(1, 1'b0);
        wait_done(cyc, dn, er);
        check_val("ovf_busy", 64'(cyc), 64'd6);
        check_val("ovf_set", 64'(bus.ovf), 64'(exp_ovf));
        check_c(1, "ovf");
        host_write(2, 0, 0, 32'd3);
        host_write(1, 0, 0, 32'hFFFF_FFFC);
        model_mul(1, 1'b0);
        pulse_start(1, 1'b0);
        wait_done(cyc, dn, er);
        check_val("ovf_clr", 64'(bus.ovf), 64'(exp_ovf));
        check_c(1, "neg");

        // Illegal dimensions: zero and MAX_N+1.
        for (int t = 0; t < 2; t++) begin
            pulse_start((t == 0) ? 0 : MAX_N + 1, 1'b0);
            check_val($sformatf("bad%0d_doneerr", t), 64'({bus.done, bus.err}), 64'd3);
            wait_done(cyc, dn, er);
            check_val($sformatf("bad%0d_busy", t), 64'(cyc), 64'd1);
            check_val($sformatf("bad%0d_err", t), 64'(er), 64'd1);
            check_c(1, $sformatf("bad%0d", t));
        end

        // Host access and start while busy are ignored.
        load_ab2();
        model_mul(2, 1'b0);
        pulse_start(2, 1'b0);
        bus.wen = 3'b100; bus.ren = 3'b001; bus.addr = '0; bus.wdata = 32'h0000_DEAD;
        bus.dim = 4'd2; bus.start = 1'b1;
        exp_q.push_back(32'd0);
        tag_q.push_back("busy_rdata");
        tick();
        bus.wen = 3'b000; bus.ren = 3'b000; bus.start = 1'b0;
        check_val(tag_q.pop_front(), 64'(bus.rdata), 64'(exp_q.pop_front()));
        wait_done(cyc, dn, er);
        check_val("bsy_busy", 64'(cyc + 1), 64'd25);
        check_val("bsy_done", 64'(dn), 64'd1);
        bsy = 0;
        for (int t = 0; t < 30; t++) begin
            if (bus.busy === 1'b1) bsy++;
            tick();
        end
        check_val("bsy_nostart", 64'(bsy), 64'd0);
        host_read(2, 0, 0, ma[0], "bsy_a00");
        check_c(2, "bsy");

        // Full-size identity x random, with a reset mid-run, then a clean rerun.
        for (int r = 0; r < MAX_N; r++) begin
            for (int c = 0; c < MAX_N; c++) begin
                host_write(2, r, c, (r == c) ? 32'd1 : 32'd0);
                host_write(1, r, c, $urandom());
            end
        end
        pulse_start(MAX_N, 1'b0);
        dn = 0;
        for (int t = 0; t < 100; t++) begin
            if (bus.done === 1'b1) dn++;
            tick();
        end
        RST = 1'b1;
        tick();
        check_val("mid_rst_busy", 64'(bus.busy), 64'd0);
        check_val("mid_rst_done", 64'(dn + int'(bus.done)), 64'd0);
        RST = 1'b0;
        model_mul(MAX_N, 1'b0);
        pulse_start(MAX_N, 1'b0);
        wait_done(cyc, dn, er);
        check_val("id_busy", 64'(cyc), 64'(MAX_N * MAX_N * (MAX_N + 4) + 1));
        check_val("id_done", 64'(dn), 64'd1);
        check_val("id_ovf", 64'(bus.ovf), 64'd0);
        for (int r = 0; r < MAX_N; r++) begin
            for (int c = 0; c < MAX_N; c++) begin
                host_read(0, r, c, mb[r*MAX_N + c], $sformatf("id_c%0d%0d", r, c));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
